bnn_xnor_acc: RTL and testbench

Parametrised successor to the single-stage XOR register of the binary-NN datapath. Each beat takes a VEC_W-bit activation vector x and weight vector w, forms XNOR and its popcount, and accumulates the bipolar dot product over BEATS beats. After the last beat it emits one neuron result: the signed sum and a thresholded activation bit. Sits between the activation/weight memory readers and the activation write-back buffer, with valid/ready handshakes on both sides.

---
 rtl/bnn_pkg.sv | 24 ++
 rtl/bnn_xnor_acc_if.sv | 39 +++
 rtl/bnn_popcount.sv | 25 ++
 rtl/bnn_xnor_acc.sv | 169 ++++++++++++++++
 tb/tb_bnn_xnor_acc.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-NN datapath: ceil-log2 helper, bipolar
// bit encoding and the default vector/beat/accumulator sizes that the
// activation/weight memory readers also use.
package bnn_pkg;

   localparam int DEF_VEC_W = 16;
   localparam int DEF_BEATS = 4;
   localparam int DEF_ACC_W = 12;

   // Bipolar encoding: a stored 1 stands for +1, a stored 0 for -1.
   localparam logic BIT_POS = 1'b1;
   localparam logic BIT_NEG = 1'b0;

   // Ceil-log2 with a floor of 1, usable in constant expressions.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/bnn_xnor_acc_if.sv
// Beat-in / neuron-out handshake bundle for bnn_xnor_acc.
// Optional macro BNN_XNOR_ACC_SAT_EN adds the saturation flag 'sat'.
interface bnn_xnor_acc_if #(
   parameter int VEC_W = 16,
   parameter int ACC_W = 12
);
   logic                    in_valid;
   logic                    in_ready;
   logic [VEC_W-1:0]        in_x;
   logic [VEC_W-1:0]        in_w;
   logic signed [ACC_W-1:0] thresh;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_sum;
   logic                    out_bit;
   logic                    busy;
`ifdef BNN_XNOR_ACC_SAT_EN
   logic                    sat;
`endif

   // Producer/consumer side (memory readers + write-back buffer).
   modport master (
      output in_valid, in_x, in_w, thresh, out_ready,
      input  in_ready, out_valid, out_sum, out_bit, busy
`ifdef BNN_XNOR_ACC_SAT_EN
     ,input  sat
`endif
   );

   // Accumulator side.
   modport slave (
      input  in_valid, in_x, in_w, thresh, out_ready,
      output in_ready, out_valid, out_sum, out_bit, busy
`ifdef BNN_XNOR_ACC_SAT_EN
     ,output sat
`endif
   );

endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count of a VEC_W-bit vector.
module bnn_popcount
   import bnn_pkg::*;
#(
   parameter int VEC_W = 16
) (
   input  logic [VEC_W-1:0]              i_vec,
   output logic [clog2(VEC_W+1)-1:0]     o_cnt
);

   localparam int CNT_W = clog2(VEC_W + 1);

   logic [CNT_W-1:0] w_sum;

   // Sum every bit of the vector; synthesis balances this into an adder tree.
   always_comb begin
      w_sum = {CNT_W{1'b0}};
      for (int i = 0; i < VEC_W; i++) begin
         w_sum = w_sum + CNT_W'(i_vec[i]);
      end
   end

   assign o_cnt = w_sum;

endmodule

// File: rtl/bnn_xnor_acc.sv
// Binary-NN neuron: per beat XNOR + popcount of x/w, bipolar contribution
// 2*pop - VEC_W accumulated over BEATS beats, then one signed sum and a
// thresholded activation bit through a one-deep output register.
// Optional macro BNN_XNOR_ACC_SAT_EN: saturating arithmetic plus 'sat' flag;
// without it the accumulator wraps modulo 2^ACC_W.
module bnn_xnor_acc
   import bnn_pkg::*;
#(
   parameter int VEC_W = DEF_VEC_W,
   parameter int BEATS = DEF_BEATS,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic            clk,
   input  logic            rst,
   bnn_xnor_acc_if.slave   bus
);

   localparam int BCNT_W = clog2(BEATS);
   localparam int PC_W   = clog2(VEC_W + 1);
   localparam int CW     = PC_W + 2;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_LAST  = 1'b1;

   logic [VEC_W-1:0]        w_xnor;
   logic [PC_W-1:0]         w_pcnt;
   logic signed [CW-1:0]    w_contrib;
   logic signed [ACC_W:0]   w_sum_wide;
   logic signed [ACC_W-1:0] w_sum;
   logic                    w_ge;
   logic                    w_in_ready;
   logic                    w_accept;
   logic [0:0]              w_state;

   logic signed [ACC_W-1:0] r_acc;
   logic [BCNT_W-1:0]       r_beat_cnt;
   logic                    r_out_valid;
   logic signed [ACC_W-1:0] r_out_sum;
   logic                    r_out_bit;

   logic signed [ACC_W-1:0] w_acc_nxt;
   logic [BCNT_W-1:0]       w_cnt_nxt;
   logic                    w_ov_nxt;
   logic signed [ACC_W-1:0] w_os_nxt;
   logic                    w_ob_nxt;

`ifdef BNN_XNOR_ACC_SAT_EN
   logic                    w_ovf;
   logic                    r_sat_stk;
   logic                    r_sat;
   logic                    w_stk_nxt;
   logic                    w_sat_nxt;
`endif

   // Matching bit positions contribute +1, mismatches -1.
   assign w_xnor = ~(bus.in_x ^ bus.in_w);

   bnn_popcount #(.VEC_W(VEC_W)) u_popcount (
      .i_vec (w_xnor),
      .o_cnt (w_pcnt)
   );

   assign w_contrib  = $signed({1'b0, w_pcnt, 1'b0}) - $signed(CW'(VEC_W));
   assign w_sum_wide = $signed({r_acc[ACC_W-1], r_acc}) + (ACC_W+1)'(w_contrib);

   // Form the accumulate result: wrap, or clamp when the extra sign bit disagrees.
   always_comb begin
`ifdef BNN_XNOR_ACC_SAT_EN
      w_ovf = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
      if (w_ovf) begin
         if (w_sum_wide[ACC_W]) begin
            w_sum = {1'b1, {(ACC_W-1){1'b0}}};
         end else begin
            w_sum = {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else begin
         w_sum = w_sum_wide[ACC_W-1:0];
      end
`else
      w_sum = w_sum_wide[ACC_W-1:0];
`endif
   end

   assign w_ge       = (w_sum >= bus.thresh);
   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_state    = (r_beat_cnt == BCNT_W'(BEATS - 1)) ? ST_LAST : ST_ACCUM;

   // Next-state: accumulate on ordinary beats, publish and clear on the last one.
   always_comb begin
      w_acc_nxt = r_acc;
      w_cnt_nxt = r_beat_cnt;
      w_ov_nxt  = r_out_valid;
      w_os_nxt  = r_out_sum;
      w_ob_nxt  = r_out_bit;
`ifdef BNN_XNOR_ACC_SAT_EN
      w_stk_nxt = r_sat_stk;
      w_sat_nxt = r_sat;
`endif
      if (w_accept) begin
         case (w_state)
            ST_ACCUM: begin
               w_acc_nxt = w_sum;
               w_cnt_nxt = r_beat_cnt + BCNT_W'(1'b1);
               // Accepting implies the output slot is empty or draining now.
               w_ov_nxt  = 1'b0;
`ifdef BNN_XNOR_ACC_SAT_EN
               w_stk_nxt = r_sat_stk | w_ovf;
`endif
            end
            ST_LAST: begin
               w_acc_nxt = {ACC_W{1'b0}};
               w_cnt_nxt = {BCNT_W{1'b0}};
               w_ov_nxt  = 1'b1;
               w_os_nxt  = w_sum;
               w_ob_nxt  = w_ge;
`ifdef BNN_XNOR_ACC_SAT_EN
               w_sat_nxt = r_sat_stk | w_ovf;
               w_stk_nxt = 1'b0;
`endif
            end
            default: begin
               w_acc_nxt = {ACC_W{1'b0}};
               w_cnt_nxt = {BCNT_W{1'b0}};
               w_ov_nxt  = 1'b0;
            end
         endcase
      end else if (r_out_valid && bus.out_ready) begin
         w_ov_nxt = 1'b0;
      end else begin
         w_ov_nxt = r_out_valid;
      end
   end

   // State registers; reset abandons any partially accumulated neuron.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= {ACC_W{1'b0}};
         r_beat_cnt  <= {BCNT_W{1'b0}};
         r_out_valid <= 1'b0;
         r_out_sum   <= {ACC_W{1'b0}};
         r_out_bit   <= 1'b0;
`ifdef BNN_XNOR_ACC_SAT_EN
         r_sat_stk   <= 1'b0;
         r_sat       <= 1'b0;
`endif
      end else begin
         r_acc       <= w_acc_nxt;
         r_beat_cnt  <= w_cnt_nxt;
         r_out_valid <= w_ov_nxt;
         r_out_sum   <= w_os_nxt;
         r_out_bit   <= w_ob_nxt;
`ifdef BNN_XNOR_ACC_SAT_EN
         r_sat_stk   <= w_stk_nxt;
         r_sat       <= w_sat_nxt;
`endif
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sum   = r_out_sum;
   assign bus.out_bit   = r_out_bit;
   assign bus.busy      = (r_beat_cnt != {BCNT_W{1'b0}});
`ifdef BNN_XNOR_ACC_SAT_EN
   assign bus.sat       = r_sat;
`endif

endmodule

// File: tb/tb_bnn_xnor_acc.sv
// Self-checking bench for bnn_xnor_acc: directed vector table, hand-written
// stall/reset/back-to-back sequences, randomized traffic against a reference
// model, and a narrow-accumulator overflow case (BNN_XNOR_ACC_SAT_EN aware).
module tb_bnn_xnor_acc;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   bnn_xnor_acc_if #(.VEC_W(16), .ACC_W(12)) bus  ();
   bnn_xnor_acc_if #(.VEC_W(16), .ACC_W(6))  bus6 ();

   bnn_xnor_acc #(.VEC_W(16), .BEATS(4), .ACC_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bnn_xnor_acc #(.VEC_W(16), .BEATS(4), .ACC_W(6)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (bus6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] xs;
      logic [63:0] ws;
      int          thr;
      int          exp_sum;
      int          exp_bit;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: bipolar dot product = (#matches) - (#mismatches).
   function automatic int beat_c(input logic [15:0] x, input logic [15:0] w);
      int m;
      m = 0;
      for (int i = 0; i < 16; i++) m += (x[i] == w[i]) ? 1 : 0;
      return m - (16 - m);
   endfunction

   function automatic int wrap12(input int v);
      logic signed [11:0] t;
      t = 12'(v);
      return int'(t);
   endfunction

   function automatic int model_sum(input logic [63:0] xs, input logic [63:0] ws);
      int s;
      s = 0;
      for (int b = 0; b < 4; b++) s += beat_c(xs[b*16 +: 16], ws[b*16 +: 16]);
      return wrap12(s);
   endfunction

   // Present four beats, one per cycle; returns just after the last accept edge.
   task automatic run_neuron(input logic [63:0] xs, input logic [63:0] ws, input int thr);
      for (int b = 0; b < 4; b++) begin
         bus.in_valid = 1'b1;
         bus.in_x     = xs[b*16 +: 16];
         bus.in_w     = ws[b*16 +: 16];
         bus.thresh   = 12'(thr);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic [63:0] rx0, rw0, rx1, rw1;
      int exp0, exp1, nres, cyc0, cyc1, sum0, sum1, rdy_drops;
      int m_acc, m_cnt, m_valid, m_sum, m_bit, thr_cur, exp_ready, neurons;
      logic acc_now;

      rst = 1'b1;
      bus.in_valid  = 1'b0;  bus.in_x  = 16'h0000; bus.in_w  = 16'h0000;
      bus.thresh    = 12'sd0; bus.out_ready  = 1'b1;
      bus6.in_valid = 1'b0;  bus6.in_x = 16'h0000; bus6.in_w = 16'h0000;
      bus6.thresh   = 6'sd0;  bus6.out_ready = 1'b1;

      tbl[0] = '{xs: {4{16'hA5A5}}, ws: {4{16'hA5A5}}, thr: 0,   exp_sum: 64,  exp_bit: 1};
      tbl[1] = '{xs: {4{16'hFFFF}}, ws: {4{16'h0000}}, thr: 0,   exp_sum: -64, exp_bit: 0};
      tbl[2] = '{xs: {4{16'hFFFF}}, ws: {4{16'h00FF}}, thr: 0,   exp_sum: 0,   exp_bit: 1};
      tbl[3] = '{xs: {4{16'hA5A5}}, ws: {4{16'hA5A5}}, thr: 65,  exp_sum: 64,  exp_bit: 0};
      tbl[4] = '{xs: {4{16'hFFFF}}, ws: {4{16'h0FFF}}, thr: 32,  exp_sum: 32,  exp_bit: 1};
      tbl[5] = '{xs: {4{16'hFFFF}}, ws: {4{16'h0000}}, thr: -64, exp_sum: -64, exp_bit: 1};

      // Reset state.
      #12;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_sum",   int'(bus.out_sum),   0);
      chk("rst_out_bit",   int'(bus.out_bit),   0);
      chk("rst_busy",      int'(bus.busy),      0);
      chk("rst_in_ready",  int'(bus.in_ready),  1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed vector table.
      for (int i = 0; i < 6; i++) begin
         run_neuron(tbl[i].xs, tbl[i].ws, tbl[i].thr);
         chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), 1);
         chk($sformatf("tbl%0d_sum", i),   int'(bus.out_sum),   tbl[i].exp_sum);
         chk($sformatf("tbl%0d_bit", i),   int'(bus.out_bit),   tbl[i].exp_bit);
         chk($sformatf("tbl%0d_busy", i),  int'(bus.busy),      0);
`ifdef BNN_XNOR_ACC_SAT_EN
         chk($sformatf("tbl%0d_sat", i),   int'(bus.sat),       0);
`endif
      end
      @(posedge clk);
      #1;
      chk("drain_valid", int'(bus.out_valid), 0);
      chk("drain_sum_kept", int'(bus.out_sum), -64);

      // Back-to-back: eight beats, two results four cycles apart.
      rx0 = {$urandom, $urandom}; rw0 = {$urandom, $urandom};
      rx1 = {$urandom, $urandom}; rw1 = {$urandom, $urandom};
      exp0 = model_sum(rx0, rw0);
      exp1 = model_sum(rx1, rw1);
      nres = 0; cyc0 = -1; cyc1 = -1; sum0 = 0; sum1 = 0; rdy_drops = 0;
      bus.thresh = 12'sd0;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            bus.in_valid = 1'b1;
            bus.in_x = (k < 4) ? rx0[k*16 +: 16] : rx1[(k-4)*16 +: 16];
            bus.in_w = (k < 4) ? rw0[k*16 +: 16] : rw1[(k-4)*16 +: 16];
            if (!bus.in_ready) rdy_drops++;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            if (nres == 0) begin cyc0 = k + 1; sum0 = int'(bus.out_sum); end
            if (nres == 1) begin cyc1 = k + 1; sum1 = int'(bus.out_sum); end
            nres++;
         end
      end
      chk("b2b_results", nres, 2);
      chk("b2b_cycle0", cyc0, 4);
      chk("b2b_cycle1", cyc1, 8);
      chk("b2b_sum0", sum0, exp0);
      chk("b2b_sum1", sum1, exp1);
      chk("b2b_ready_drops", rdy_drops, 0);

      // Backpressure: result held three cycles, next beat taken when out_ready rises.
      rx0 = {$urandom, $urandom}; rw0 = {$urandom, $urandom};
      rx1 = {$urandom, $urandom}; rw1 = {$urandom, $urandom};
      exp0 = model_sum(rx0, rw0);
      exp1 = model_sum(rx1, rw1);
      run_neuron(rx0, rw0, 0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_x = rx1[15:0];
      bus.in_w = rw1[15:0];
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", k), int'(bus.in_ready), 0);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_valid", k), int'(bus.out_valid), 1);
         chk($sformatf("bp%0d_sum", k),   int'(bus.out_sum),   exp0);
         chk($sformatf("bp%0d_busy", k),  int'(bus.busy),      0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      chk("bp_first_beat_busy", int'(bus.busy), 1);
      chk("bp_drained", int'(bus.out_valid), 0);
      for (int b = 1; b < 4; b++) begin
         bus.in_x = rx1[b*16 +: 16];
         bus.in_w = rw1[b*16 +: 16];
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("bp_next_valid", int'(bus.out_valid), 1);
      chk("bp_next_sum", int'(bus.out_sum), exp1);

      // Reset mid-neuron discards the partial sum.
      @(posedge clk);
      #1;
      rx0 = {4{16'hFFFF}}; rw0 = {4{16'hFFFF}};
      for (int b = 0; b < 2; b++) begin
         bus.in_valid = 1'b1;
         bus.in_x = rx0[b*16 +: 16];
         bus.in_w = rw0[b*16 +: 16];
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("pre_rst_busy", int'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_valid", int'(bus.out_valid), 0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_neuron({4{16'h1234}}, {4{16'h1234}}, 0);
      chk("post_rst_valid", int'(bus.out_valid), 1);
      chk("post_rst_sum", int'(bus.out_sum), 64);
      chk("post_rst_bit", int'(bus.out_bit), 1);

      // Randomized traffic against the reference model.
      @(posedge clk);
      #1;
      m_acc = 0; m_cnt = 0; m_valid = 0; m_sum = 0; m_bit = 0; neurons = 0;
      thr_cur = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_x      = 16'($urandom);
         bus.in_w      = 16'($urandom);
         if (m_cnt == 0) begin
            thr_cur    = int'($urandom_range(0, 128)) - 64;
            bus.thresh = 12'(thr_cur);
         end
         #1;
         exp_ready = (m_valid == 0 || bus.out_ready) ? 1 : 0;
         chk("rnd_in_ready", int'(bus.in_ready), exp_ready);
         acc_now = bus.in_valid && (exp_ready == 1);
         if (acc_now && m_cnt == 3) begin
            m_sum   = wrap12(m_acc + beat_c(bus.in_x, bus.in_w));
            m_bit   = (m_sum >= thr_cur) ? 1 : 0;
            m_valid = 1;
            m_acc   = 0;
            m_cnt   = 0;
            neurons++;
         end else begin
            if (acc_now) begin
               m_acc += beat_c(bus.in_x, bus.in_w);
               m_cnt++;
            end
            m_valid = (m_valid == 1 && !bus.out_ready) ? 1 : 0;
         end
         @(posedge clk);
         #1;
         chk("rnd_valid", int'(bus.out_valid), m_valid);
         chk("rnd_busy", int'(bus.busy), (m_cnt != 0) ? 1 : 0);
         if (m_valid == 1) begin
            chk("rnd_sum", int'(bus.out_sum), m_sum);
            chk("rnd_bit", int'(bus.out_bit), m_bit);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("rnd_some_neurons", (neurons > 5) ? 1 : 0, 1);

      // Narrow accumulator: four all-match beats total +64 against ACC_W=6.
      for (int b = 0; b < 4; b++) begin
         bus6.in_valid = 1'b1;
         bus6.in_x = 16'hFFFF;
         bus6.in_w = 16'hFFFF;
         @(posedge clk);
         #1;
      end
      bus6.in_valid = 1'b0;
      chk("acc6_valid", int'(bus6.out_valid), 1);
      chk("acc6_bit", int'(bus6.out_bit), 1);
`ifdef BNN_XNOR_ACC_SAT_EN
      chk("acc6_sum_sat", int'(bus6.out_sum), 31);
      chk("acc6_sat_flag", int'(bus6.sat), 1);
`else
      chk("acc6_sum_wrap", int'(bus6.out_sum), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
